uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receiver on the board's serial input (uart_rxd): 8N1, LSB first, fixed baud set by DIV.
//  Synchronises the pin, validates the start bit, samples each bit at mid-period, checks the stop bit.
//  Holds one received byte for the bus-side UART register block; the CPU clears it with rx_ack.
//  Complements the existing serial transmit path driving uart_txd.
// PARAMETERS
//  DIV      217  clock cycles per bit (25 MHz / 115200); legal range 4..65535
//  CNT_W    16   width of the baud counter; must hold DIV-1
// PORTS
//  clk_in     in   1  system clock, rising edge
//  sys_rstn   in   1  asynchronous, active-low reset
//  uart_rxd   in   1  serial line, idle high, asynchronous to clk_in
//  rx_ack     in   1  one-cycle pulse: byte consumed; clears rx_valid, frame_err, overrun
//  rx_data    out  8  last good byte, stable while rx_valid=1
//  rx_valid   out  1  holding register full
//  frame_err  out  1  sticky: stop bit sampled low
//  overrun    out  1  sticky: good byte arrived while rx_valid=1 and no rx_ack that cycle
//  rx_busy    out  1  FSM not in IDLE
// BEHAVIOUR
//  Clock/reset: one clock (clk_in). Reset is asynchronous and active-low (sys_rstn).
//  Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
//    Synchroniser flops=1. FSM=IDLE. Counters=0.
//  Sync: 2-flop synchroniser; rxs = second stage. All decisions use rxs (2-cycle pin delay).
//  FSM states: IDLE, START, DATA, STOP, WAIT_HI.
//   IDLE: on rxs==0 -> START, cnt=0.
//   START: cnt counts to DIV/2-1 (integer divide); sample rxs at that count.
//    rxs==1 -> glitch, back to IDLE, no flags. rxs==0 -> DATA, cnt=0, bit_idx=0.
//   DATA: sample at cnt==DIV-1, then cnt=0; shift into shreg[7] and shift right, so LSB comes first.
//    After bit_idx 7 is sampled -> STOP.
//   STOP: sample at cnt==DIV-1.
//    rxs==1 -> good byte -> IDLE.
//    rxs==0 -> frame_err<=1, byte discarded -> WAIT_HI.
//   WAIT_HI: stay until rxs==1, then IDLE. A break condition therefore produces exactly one frame_err.
//  Good byte, rx_valid=0 or rx_ack=1 same cycle: rx_data<=shreg and rx_valid<=1 on the clock edge after the stop sample.
//    Load wins over ack; no overrun is flagged.
//  Good byte, rx_valid=1 and rx_ack=0: new byte dropped; rx_data is unchanged; overrun<=1.
//  rx_ack with no load in that cycle: rx_valid, frame_err, overrun <=0 next edge.
//    A flag set in the same cycle as rx_ack stays set (set wins).
//  Latency: rx_valid rises 2 + DIV/2 + 9*DIV + 2 cycles after the pin falling edge (+/-1 for async pin).
//  Back-to-back frames: a start edge is accepted on the first cycle after the STOP return to IDLE. There is no dead time.
//  Reset mid-frame: everything is cleared immediately. The next frame is hunted from IDLE.
//    If the line is low at release, this is treated as a start.
//  rx_busy=1 in START, DATA, STOP and WAIT_HI.
// TESTING (bench: DIV=8, bit period 8 clocks)
//  1. Send 0x55 8N1 -> rx_valid=1, rx_data=0x55, frame_err=0. Pulse rx_ack -> rx_valid=0 next cycle.
//  2. Low glitch of 3 clocks on idle line -> FSM back to IDLE, rx_valid=0, no flags.
//  3. Send 0xA3 with stop bit=0, line then high -> frame_err=1, rx_valid=0.
//     A following 0x3C is received correctly.
//  4. Send 0x12 then 0x34 back-to-back with no ack -> rx_data=0x12, overrun=1.
//     Ack -> all cleared.
//  5. Ack in the exact load cycle of 0x7E -> rx_valid=1, rx_data=0x7E, overrun=0.
//  6. Assert sys_rstn=0 mid-DATA of 0xFF, then release. Send 0x01 -> rx_data=0x01, no flags.
//  7. Hold line low for 30 bit periods -> single frame_err, rx_busy=1 until the line goes high.

Source files
------------

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver for the board's serial input. The frame format is 8N1, LSB
// first, and the baud rate is fixed by DIV. The receiver synchronises the pin,
// validates the start bit and samples each data bit at mid-period. It then
// checks the stop bit and holds one good byte for the bus-side UART register
// block. The CPU releases that byte with rx_ack.
//
// Parameters
//   DIV       clock cycles per bit (legal 4..65535)
//   CNT_W     width of the baud counter, must hold DIV-1
//
// Ports
//   clk_in    in   1  system clock, rising edge
//   sys_rstn  in   1  asynchronous, active-low reset
//   uart_rxd  in   1  serial line, idle high, asynchronous to clk_in
//   rx_ack    in   1  one-cycle pulse: byte consumed; clears rx_valid,
//                     frame_err, overrun
//   rx_data   out  8  last good byte, stable while rx_valid=1
//   rx_valid  out  1  holding register full
//   frame_err out  1  sticky: stop bit sampled low
//   overrun   out  1  sticky: good byte arrived while rx_valid=1, no rx_ack
//   rx_busy   out  1  receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int unsigned DIV   = 217,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk_in,
    input  logic       sys_rstn,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    // Terminal counts. The start bit is checked at its middle. Every later
    // sample then falls one full bit period after the previous one.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

    logic             rx_meta;
    logic             rxs;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             load_pend;

    // Two-flop synchroniser. Both stages reset to the idle line level, so
    // reset does not look like a start bit unless the pin is actually low.
    // NOTE: every flop in this design, including the data holding register,
    // has a reset value, so outputs are defined immediately after reset.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the second stage take the
            // previous value of the first stage, which forms a true two-flop
            // chain.
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM plus the holding register. Everything is in one process
    // so that the priority between ack clears and flag sets is visible.
    // Clears are written first. The sets further down override them, so a
    // flag set in the same cycle as rx_ack stays set.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            load_pend <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            // Holding register. A byte validated on the previous edge is
            // loaded now. The load wins over a simultaneous ack.
            if (load_pend) begin
                load_pend <= 1'b0;
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;    // new byte dropped, rx_data kept
                end
            end else if (rx_ack) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state   <= S_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            // The line is high again at mid-start, so the
                            // low was a glitch. Drop it silently.
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // Each bit enters at the MSB and moves right, so the
                        // first bit received (the LSB) ends up in shreg[0].
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            // Return to IDLE at once so that a back-to-back
                            // start edge is seen on the very next cycle.
                            load_pend <= 1'b1;
                            state     <= S_IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WAIT_HI: begin
                    // A break holds the line low. Wait for it to end so the
                    // break gives one frame error, not one per bit period.
                    if (rxs) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//
// Testbench for uart_rx_core with DIV=8. The stimulus side drives serial
// frames. For each frame it also predicts, from the receiver's externally
// visible rules, which holding-register event should follow: a new byte, a
// frame error rising, or an overrun rising. That prediction is pushed into a
// queue. A monitor watches the DUT outputs on the falling clock edge and pops
// and compares an entry for every event it sees. Directed checks cover the
// specific scenarios on top of that.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int DIV = 8;

    logic       clk_in   = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ack   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_rx_core #(.DIV(DIV), .CNT_W(16)) dut (
        .clk_in    (clk_in),
        .sys_rstn  (sys_rstn),
        .uart_rxd  (uart_rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk_in = ~clk_in;

    typedef enum int {EV_BYTE = 1, EV_FERR = 2, EV_OVR = 3} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model of the holding register as seen by the CPU.
    bit m_valid = 1'b0;
    bit m_ferr  = 1'b0;
    bit m_ovr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Predict the visible effect of one complete frame.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit ack_in_load);
        if (!stop_ok) begin
            if (!m_ferr) push_ev(EV_FERR, 8'h00);
            m_ferr = 1'b1;
        end else if (m_valid && !ack_in_load) begin
            if (!m_ovr) push_ev(EV_OVR, 8'h00);
            m_ovr = 1'b1;
        end else begin
            push_ev(EV_BYTE, d);
            m_valid = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
        model_clear();
    endtask

    // Drives one 8N1 frame. The caller must be 1 time unit after a rising
    // edge. The task returns 1 time unit after the edge that ends the stop
    // bit, and leaves the line high.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit);
        uart_rxd = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_cycles(DIV);
        end
        uart_rxd = stop_bit;
        wait_cycles(DIV);
        uart_rxd = 1'b1;
    endtask

    // Monitor: turns output changes into events and matches them against the
    // queue of predictions.
    task automatic mon_event(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == EV_BYTE && kind == EV_BYTE) check("event_data", data, e.data);
        end
    endtask

    logic       p_valid = 1'b0;
    logic [7:0] p_data  = 8'h00;
    logic       p_ferr  = 1'b0;
    logic       p_ovr   = 1'b0;

    always @(negedge clk_in) begin
        if (!sys_rstn) begin
            p_valid = 1'b0;
            p_data  = 8'h00;
            p_ferr  = 1'b0;
            p_ovr   = 1'b0;
        end else begin
            if (rx_valid && (!p_valid || rx_data != p_data)) mon_event(EV_BYTE, rx_data);
            if (frame_err && !p_ferr) mon_event(EV_FERR, 8'h00);
            if (overrun && !p_ovr) mon_event(EV_OVR, 8'h00);
            p_valid = rx_valid;
            p_data  = rx_data;
            p_ferr  = frame_err;
            p_ovr   = overrun;
        end
    end

    initial begin
        int busy_low;

        // Reset state
        wait_cycles(3);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        sys_rstn = 1'b1;
        wait_cycles(3);

        // 1. Plain byte, then ack
        model_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1);
        wait_cycles(2);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_data", rx_data, 8'h55);
        check("t1_ferr", frame_err, 1'b0);
        do_ack();
        check("t1_valid_after_ack", rx_valid, 1'b0);

        // 2. Three-clock low glitch on an idle line
        uart_rxd = 1'b0;
        wait_cycles(3);
        uart_rxd = 1'b1;
        check("t2_busy_in_start", rx_busy, 1'b1);
        wait_cycles(12);
        check("t2_busy", rx_busy, 1'b0);
        check("t2_valid", rx_valid, 1'b0);
        check("t2_ferr", frame_err, 1'b0);
        check("t2_ovr", overrun, 1'b0);

        // 3. Bad stop bit, then a clean frame
        model_frame(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0);
        wait_cycles(6);
        check("t3_ferr", frame_err, 1'b1);
        check("t3_valid", rx_valid, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1);
        wait_cycles(2);
        check("t3_valid2", rx_valid, 1'b1);
        check("t3_data2", rx_data, 8'h3C);
        do_ack();
        check("t3_ferr_cleared", frame_err, 1'b0);

        // 4. Back-to-back frames without ack -> overrun
        model_frame(8'h12, 1'b1, 1'b0);
        model_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_cycles(2);
        check("t4_data", rx_data, 8'h12);
        check("t4_ovr", overrun, 1'b1);
        check("t4_valid", rx_valid, 1'b1);
        do_ack();
        check("t4_valid_clr", rx_valid, 1'b0);
        check("t4_ovr_clr", overrun, 1'b0);
        check("t4_ferr_clr", frame_err, 1'b0);

        // 5. Ack lands in the exact load cycle of the next byte
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1);
        wait_cycles(2);
        model_frame(8'h7E, 1'b1, 1'b1);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                // The stop sample is on edge 79 after the start drive. The
                // load is on edge 80, so ack must be high across edge 80.
                repeat (79) @(posedge clk_in);
                #1 rx_ack = 1'b1;
                @(posedge clk_in);
                #1 rx_ack = 1'b0;
            end
        join
        wait_cycles(2);
        check("t5_valid", rx_valid, 1'b1);
        check("t5_data", rx_data, 8'h7E);
        check("t5_ovr", overrun, 1'b0);

        // 6. Reset in the middle of a 0xFF frame
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_cycles(30);
                check("t6_busy_mid", rx_busy, 1'b1);
                sys_rstn = 1'b0;
                #1;
                check("t6_valid_rst", rx_valid, 1'b0);
                check("t6_busy_rst", rx_busy, 1'b0);
                model_clear();
                wait_cycles(9);
                sys_rstn = 1'b1;
            end
        join
        wait_cycles(4);
        check("t6_busy_after", rx_busy, 1'b0);
        check("t6_valid_after", rx_valid, 1'b0);
        model_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1);
        wait_cycles(2);
        check("t6_data", rx_data, 8'h01);
        check("t6_ferr", frame_err, 1'b0);
        check("t6_ovr", overrun, 1'b0);
        do_ack();

        // 7. Break: line low for 30 bit periods. The ack in the middle
        // clears the error. The monitor then flags any second frame error.
        model_frame(8'h00, 1'b0, 1'b0);
        busy_low = 0;
        uart_rxd = 1'b0;
        for (int i = 0; i < 30 * DIV; i++) begin
            wait_cycles(1);
            if (i >= 3 && !rx_busy) busy_low++;
            if (i == 150) rx_ack = 1'b1;
            if (i == 151) begin
                rx_ack = 1'b0;
                model_clear();
            end
        end
        check("t7_busy_gaps", busy_low, 0);
        check("t7_busy_end", rx_busy, 1'b1);
        check("t7_ferr_single", frame_err, 1'b0);
        uart_rxd = 1'b1;
        wait_cycles(5);
        check("t7_busy_released", rx_busy, 1'b0);

        // Random frames with random stop-bit errors and acks
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         ok;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            model_frame(d, ok, 1'b0);
            send_frame(d, ok);
            wait_cycles($urandom_range(4, 10));
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        wait_cycles(20);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
